// File: rtl/supermic_pkg.sv
// Shared constants and helpers for the microphone-array PDM front end.
// Sizes the CIC datapath from the decimation ratio and clamps scaled outputs.
package supermic_pkg;

    localparam int CIC_ORDER = 3;

    // Wrapping accumulator width: order*log2(R) bits of gain plus sign and one unit bit.
    function automatic int acc_width(input int decim);
        return CIC_ORDER * $clog2(decim) + 2;
    endfunction

    // Arithmetic right shift that brings full-scale CIC gain down to the output word.
    function automatic int out_shift(input int decim, input int out_w);
        return CIC_ORDER * $clog2(decim) - out_w + 1;
    endfunction

    // Clamp a signed value to the range of an out_w-bit two's complement word.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/cic_channel.sv
// One microphone channel: three wrapping integrators at the bit rate, three combs
// at the frame rate, then arithmetic scaling and saturation to the PCM word.
module cic_channel
    import supermic_pkg::*;
#(
    parameter int DECIM = 32,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             strobe,
    input  logic             frame_done,
    input  logic             pdm_bit,
    output logic [OUT_W-1:0] pcm
);

    localparam int ACC_W = acc_width(DECIM);
    localparam int SHIFT = out_shift(DECIM, OUT_W);

    logic signed [ACC_W-1:0] x;
    logic signed [ACC_W-1:0] int1, int2, int3;
    logic signed [ACC_W-1:0] dly1, dly2, dly3;
    logic signed [ACC_W-1:0] comb1, comb2, comb3;
    logic signed [ACC_W-1:0] scaled;
    logic signed [63:0]      scaled_wide;

    // A 0 bit is -1, i.e. all ones in two's complement.
    assign x = pdm_bit ? ACC_W'(1) : '1;

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        comb1       = int3 - dly1;
        comb2       = comb1 - dly2;
        comb3       = comb2 - dly3;
        scaled      = comb3 >>> SHIFT;
        scaled_wide = 64'(scaled);
    end

    // NOTE: state registers use non-blocking assignments so every stage sees the
    // previous stage's registered value, which is what makes the cascade a true CIC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int1 <= '0;
            int2 <= '0;
            int3 <= '0;
            dly1 <= '0;
            dly2 <= '0;
            dly3 <= '0;
            pcm  <= '0;
        end else if (!en) begin
            int1 <= '0;
            int2 <= '0;
            int3 <= '0;
            dly1 <= '0;
            dly2 <= '0;
            dly3 <= '0;
            pcm  <= '0;
        end else begin
            if (strobe) begin
                int1 <= int1 + x;
                int2 <= int2 + int1;
                int3 <= int3 + int2;
            end
            if (frame_done) begin
                dly1 <= int3;
                dly2 <= comb1;
                dly3 <= comb2;
                pcm  <= OUT_W'(saturate(scaled_wide, OUT_W));
            end
        end
    end

endmodule

// File: rtl/pdm_cic_decimator.sv
// Multi-channel PDM front end: shared mic clock divider, sample strobe and
// decimation counter driving one CIC decimator per microphone.
module pdm_cic_decimator
    import supermic_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int MIC_DIV = 4,
    parameter int DECIM   = 32,
    parameter int OUT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NUM_CH-1:0]       pdm,
    output logic                    mic_clk,
    output logic [NUM_CH*OUT_W-1:0] pcm_out,
    output logic                    pcm_valid
);

    localparam int DIV_W = (MIC_DIV > 1) ? $clog2(MIC_DIV) : 1;
    localparam int DEC_W = $clog2(DECIM);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [DEC_W-1:0] dec_cnt;
    logic             strobe;
    logic             frame_done;

    always_comb begin
        div_nxt = (div_cnt == DIV_W'(MIC_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
        strobe  = (div_cnt == DIV_W'(MIC_DIV - 1));
    end

    // mic_clk is registered from the next count so it is high while div_cnt is in
    // the upper half; the strobe therefore lands on the last high cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt    <= '0;
            dec_cnt    <= '0;
            mic_clk    <= 1'b0;
            frame_done <= 1'b0;
            pcm_valid  <= 1'b0;
        end else if (!en) begin
            div_cnt    <= '0;
            dec_cnt    <= '0;
            mic_clk    <= 1'b0;
            frame_done <= 1'b0;
            pcm_valid  <= 1'b0;
        end else begin
            div_cnt    <= div_nxt;
            mic_clk    <= (div_nxt >= DIV_W'(MIC_DIV / 2));
            if (strobe) dec_cnt <= dec_cnt + DEC_W'(1);
            frame_done <= strobe && (dec_cnt == DEC_W'(DECIM - 1));
            pcm_valid  <= frame_done;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        cic_channel #(
            .DECIM (DECIM),
            .OUT_W (OUT_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .strobe     (strobe),
            .frame_done (frame_done),
            .pdm_bit    (pdm[i]),
            .pcm        (pcm_out[i*OUT_W +: OUT_W])
        );
    end

endmodule
